// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the RV32I instruction fetch unit.
package ifu_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetchState_e;

    // ADDI x0,x0,0 -- presented on InstrF whenever no real instruction is held.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force an address onto a word boundary.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch-address register with redirect / sequential / hold select.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pcFetch
);

    logic [31:0] pcNext;

    // Next-PC select: a redirect beats a sequential advance; otherwise hold.
    always_comb begin
        pcNext = pcFetch;
        if (redirect) begin
            pcNext = wordAlign(target);
        end else if (advance) begin
            pcNext = pcFetch + 32'd4;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcFetch <= wordAlign(RESET_PC);
        end else begin
            pcFetch <= pcNext;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32I fetch stage. Issues one instruction-memory request at a time,
// holds the fetched word for Decode, honours stallF and Execute redirects.
// Optional build macro IFU_PERF_CNT_EN adds saturating fetch/bubble counters.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] PCplus4F,
    output logic [31:0] InstrF,
    output logic        instr_validF
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetchState_e state, stateNext;
    logic        drop, dropNext;
    logic        outValid;
    logic [31:0] outPc, outInstr;
    logic [31:0] shadowPc, shadowInstr;
    logic [31:0] reqPc;
    logic [31:0] pcFetch;
    logic        outFree;
    logic        granted;
    logic        respLive;

    // The output slot is free if empty or if Decode takes it at this edge.
    assign outFree  = !outValid || !stallF;
    assign granted  = imem_req && imem_gnt;
    // A response that is neither stale nor killed by a same-cycle redirect.
    assign respLive = (state == S_WAIT) && imem_rvalid && !drop && !pcsrcE;

    ifu_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk      (clk),
        .reset    (reset),
        .redirect (pcsrcE),
        .target   (pctargetE),
        .advance  (granted),
        .pcFetch  (pcFetch)
    );

    // FSM state and stale-response flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end else begin
            state <= stateNext;
            drop  <= dropNext;
        end
    end

    // FSM next state; a redirect overrides everything else.
    always_comb begin
        stateNext = state;
        dropNext  = drop;
        unique case (state)
            S_REQ: begin
                if (granted) stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    dropNext  = 1'b0;
                    stateNext = (drop || outFree) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stallF) stateNext = S_REQ;
            end
            default: stateNext = S_REQ;
        endcase
        if (pcsrcE) begin
            // A request still in flight must have its response absorbed.
            if ((state == S_WAIT && !imem_rvalid) || (state == S_REQ && granted)) begin
                dropNext  = 1'b1;
                stateNext = S_WAIT;
            end else begin
                dropNext  = 1'b0;
                stateNext = S_REQ;
            end
        end
    end

    // FSM outputs: request only when the response will have somewhere to go.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pcFetch;
        unique case (state)
            S_REQ:   imem_req = !reset && outFree;
            default: imem_req = 1'b0;
        endcase
    end

    // Output register, shadow slot and outstanding-request PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid    <= 1'b0;
            outPc       <= RESET_PC;
            outInstr    <= NOP_INSTR;
            shadowPc    <= RESET_PC;
            shadowInstr <= NOP_INSTR;
            reqPc       <= RESET_PC;
        end else begin
            if (granted) reqPc <= pcFetch;
            if (pcsrcE) begin
                outValid    <= 1'b0;
                outInstr    <= NOP_INSTR;
                shadowInstr <= NOP_INSTR;
            end else if (respLive && outFree) begin
                outValid <= 1'b1;
                outInstr <= imem_rdata;
                outPc    <= reqPc;
            end else if (respLive) begin
                shadowInstr <= imem_rdata;
                shadowPc    <= reqPc;
            end else if (state == S_HOLD && !stallF) begin
                outValid <= 1'b1;
                outInstr <= shadowInstr;
                outPc    <= shadowPc;
            end else if (!stallF) begin
                outValid <= 1'b0;
            end
        end
    end

    assign PCF          = outPc;
    assign PCplus4F     = outPc + 32'd4;
    assign InstrF       = outValid ? outInstr : NOP_INSTR;
    assign instr_validF = outValid;

`ifdef IFU_PERF_CNT_EN
    // Saturating counters: instructions handed to Decode and empty-slot bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (!stallF && outValid && perf_fetch_cnt != '1) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!stallF && !outValid && perf_bubble_cnt != '1) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
